// File: rtl/rcc_pkg.sv
// Shared types and constants for the RCC reset sequencer.
// Holds the sequencer state encoding and the reset-cause bit positions.
package rcc_pkg;

    typedef enum logic [1:0] {
        RS_ASSERT,
        RS_RELEASE,
        RS_RUN
    } rcc_rst_state_t;

    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_SW     = 1;
    localparam int CAUSE_WDT    = 2;
    localparam int CAUSE_LOCKUP = 3;
    localparam int CAUSE_W      = 4;

endpackage

// File: rtl/rcc_reset_sequencer.sv
// RCC reset sequencer: stretches the synchronized system reset, then
// releases per-domain resets in order (domain 0 first), re-entering reset
// on software / watchdog / optional lockup requests, with a sticky cause
// register readable by firmware.
//
// Ports:
//   CLK          system clock
//   RESET        async active-low reset (sync-deasserted upstream)
//   SW_RST_REQ   software reset request, level
//   WDT_RST_REQ  watchdog reset request, level
//   LOCKUP       CPU lockup indication, level
//   CAUSE_CLR    1-cycle pulse, clears RST_CAUSE (a same-edge set wins)
//   RST_N        per-domain active-low resets, registered
//   RST_DONE     sequence complete, all domains running
//   RST_CAUSE    sticky causes: [0] POR/pin [1] SW [2] WDT [3] LOCKUP
//
// Build option RCC_LOCKUP_RST_EN: when defined, LOCKUP is a reset request
// and sets RST_CAUSE[3]; otherwise LOCKUP is ignored and bit 3 reads 0.
module rcc_reset_sequencer
    import rcc_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SW_RST_REQ,
    input  logic                   WDT_RST_REQ,
    input  logic                   LOCKUP,
    input  logic                   CAUSE_CLR,
    output logic [NUM_DOMAINS-1:0] RST_N,
    output logic                   RST_DONE,
    output logic [CAUSE_W-1:0]     RST_CAUSE
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    // idx runs 0..NUM_DOMAINS; NUM_DOMAINS itself means "all released".
    localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_DOMAINS);

`ifdef RCC_LOCKUP_RST_EN
    localparam int CQ_W = CAUSE_W;
`else
    // Lockup bit is not stored at all in this build.
    localparam int CQ_W = CAUSE_W - 1;
`endif

    rcc_rst_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   done_q, done_d;
    logic [CQ_W-1:0]        cause_q, cause_d;
    logic                   req;

`ifdef RCC_LOCKUP_RST_EN
    assign req = SW_RST_REQ | WDT_RST_REQ | LOCKUP;
`else
    logic unused_lockup;
    assign unused_lockup = LOCKUP;
    assign req = SW_RST_REQ | WDT_RST_REQ;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= RS_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= CQ_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;

        if (req) begin
            // Any request, in any state, restarts the whole sequence.
            state_d = RS_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                RS_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d    = RS_RELEASE;
                        rst_n_d[0] = 1'b1;
                        cnt_d      = '0;
                        idx_d      = IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RS_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_END) begin
                            // One extra gap after the last domain.
                            state_d = RS_RUN;
                            done_d  = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_DOMAINS; i++) begin
                                if (idx_q == IDX_W'(i)) begin
                                    rst_n_d[i] = 1'b1;
                                end
                            end
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RS_RUN: begin
                end
                default: begin
                    state_d = RS_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Clear first, then OR in this edge's requests so a set wins.
    always_comb begin
        cause_d = CAUSE_CLR ? '0 : cause_q;
        cause_d[CAUSE_SW]  = cause_d[CAUSE_SW]  | SW_RST_REQ;
        cause_d[CAUSE_WDT] = cause_d[CAUSE_WDT] | WDT_RST_REQ;
`ifdef RCC_LOCKUP_RST_EN
        cause_d[CAUSE_LOCKUP] = cause_d[CAUSE_LOCKUP] | LOCKUP;
`endif
    end

    assign RST_N    = rst_n_q;
    assign RST_DONE = done_q;
`ifdef RCC_LOCKUP_RST_EN
    assign RST_CAUSE = cause_q;
`else
    assign RST_CAUSE = {1'b0, cause_q};
`endif

endmodule

// File: tb/tb_rcc_reset_sequencer.sv
// Scoreboard bench for rcc_reset_sequencer (default parameters).
// Stimulus queues expected outputs per edge; a monitor checks them.
module tb_rcc_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw = 1'b0;
    logic       wdt = 1'b0;
    logic       lockup = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] rst_n;
    logic       done;
    logic [3:0] cause;

    rcc_reset_sequencer dut (
        .CLK         (clk),
        .RESET       (rst),
        .SW_RST_REQ  (sw),
        .WDT_RST_REQ (wdt),
        .LOCKUP      (lockup),
        .CAUSE_CLR   (clr),
        .RST_N       (rst_n),
        .RST_DONE    (done),
        .RST_CAUSE   (cause)
    );

    always #5 clk = ~clk;

    // Edge number since the last RESET release (edge 1 = first posedge).
    int edge_no = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_no <= 0;
        else edge_no <= edge_no + 1;
    end

    typedef struct {
        int         cyc;
        logic [2:0] rn;
        logic       dn;
        logic [3:0] cs;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_at(input int c, input logic [2:0] rn,
                             input logic dn, input logic [3:0] cs);
        exp_t e;
        e.cyc = c;
        e.rn = rn;
        e.dn = dn;
        e.cs = cs;
        q.push_back(e);
    endtask

    task automatic go_to(input int k);
        while (edge_no < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < edge_no) begin
            errors++;
            checks++;
            $display("FAIL missed@%0d at edge %0d", q[0].cyc, edge_no);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == edge_no) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (rst_n !== e.rn || done !== e.dn || cause !== e.cs) begin
                errors++;
                $display("FAIL edge%0d got rst_n=%b done=%b cause=%b want rst_n=%b done=%b cause=%b",
                         e.cyc, rst_n, done, cause, e.rn, e.dn, e.cs);
            end
        end
    end

`ifdef RCC_LOCKUP_RST_EN
    localparam logic [3:0] LK = 4'b1000;
`else
    localparam logic [3:0] LK = 4'b0000;
`endif

    initial begin
        // Reset state, then power-on sequence.
        expect_at(0, 3'b000, 1'b0, 4'b0001);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        expect_at(15, 3'b000, 1'b0, 4'b0001);
        expect_at(16, 3'b001, 1'b0, 4'b0001);
        expect_at(19, 3'b001, 1'b0, 4'b0001);
        expect_at(20, 3'b011, 1'b0, 4'b0001);
        expect_at(24, 3'b111, 1'b0, 4'b0001);
        expect_at(27, 3'b111, 1'b0, 4'b0001);
        expect_at(28, 3'b111, 1'b1, 4'b0001);

        // SW pulse at edge 40, then WDT at edge 58 mid-RELEASE.
        expect_at(39, 3'b111, 1'b1, 4'b0001);
        expect_at(40, 3'b000, 1'b0, 4'b0011);
        expect_at(55, 3'b000, 1'b0, 4'b0011);
        expect_at(56, 3'b001, 1'b0, 4'b0011);
        expect_at(57, 3'b001, 1'b0, 4'b0011);
        expect_at(58, 3'b000, 1'b0, 4'b0111);
        expect_at(73, 3'b000, 1'b0, 4'b0111);
        expect_at(74, 3'b001, 1'b0, 4'b0111);
        expect_at(78, 3'b011, 1'b0, 4'b0111);
        expect_at(82, 3'b111, 1'b0, 4'b0111);
        expect_at(86, 3'b111, 1'b1, 4'b0111);
        go_to(39); sw = 1'b1;
        go_to(40); sw = 1'b0;
        go_to(57); wdt = 1'b1;
        go_to(58); wdt = 1'b0;

        // Clear with a same-edge WDT set, then clear alone.
        expect_at(90, 3'b000, 1'b0, 4'b0100);
        expect_at(91, 3'b000, 1'b0, 4'b0000);
        expect_at(106, 3'b001, 1'b0, 4'b0000);
        expect_at(118, 3'b111, 1'b1, 4'b0000);
        go_to(89); wdt = 1'b1; clr = 1'b1;
        go_to(90); wdt = 1'b0;
        go_to(91); clr = 1'b0;

        // Lockup held for edges 130..132.
`ifdef RCC_LOCKUP_RST_EN
        expect_at(130, 3'b000, 1'b0, LK);
        expect_at(132, 3'b000, 1'b0, LK);
        expect_at(147, 3'b000, 1'b0, LK);
        expect_at(148, 3'b001, 1'b0, LK);
        expect_at(160, 3'b111, 1'b1, LK);
`else
        expect_at(130, 3'b111, 1'b1, LK);
        expect_at(132, 3'b111, 1'b1, LK);
        expect_at(133, 3'b111, 1'b1, LK);
        expect_at(160, 3'b111, 1'b1, LK);
`endif
        go_to(129); lockup = 1'b1;
        go_to(132); lockup = 1'b0;

        // Into RELEASE again, then async RESET between edges.
        expect_at(170, 3'b000, 1'b0, LK | 4'b0010);
        expect_at(186, 3'b001, 1'b0, LK | 4'b0010);
        go_to(169); sw = 1'b1;
        go_to(170); sw = 1'b0;
        go_to(188);
        #1 rst = 1'b0;
        expect_at(0, 3'b000, 1'b0, 4'b0001);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d checks pending", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
